// File: rtl/mux_scan_if.sv
// Scan bus between mux_scan_sequencer and its requester/multiplexer.
interface mux_scan_if #(
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                start;
  logic                mux_y;
  logic [SEL_W-1:0]    sel;
  logic                sample_vld;
  logic [CHANNELS-1:0] result;
  logic                busy;
  logic                done;

  modport master (
    output start, mux_y,
    input  sel, sample_vld, result, busy, done
  );

  modport slave (
    input  start, mux_y,
    output sel, sample_vld, result, busy, done
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a CHANNELS:1 mux select, dwells, captures mux_y per channel.
// Define MUX_SCAN_CONT_EN for continuous back-to-back scanning.
module mux_scan_sequencer #(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 3
) (
  input logic     clk,
  input logic     rst_n,
  mux_scan_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [7:0] DW_M1 = 8'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE, SETTLE, CAPTURE, DONE
  } state_t;

  state_t              state;
  logic [7:0]          cnt;
  logic [SEL_W-1:0]    sel;
  logic [CHANNELS-1:0] result;
  logic                sample_vld;
  logic                busy;
  logic                done;

  assign bus.sel        = sel;
  assign bus.result     = result;
  assign bus.sample_vld = sample_vld;
  assign bus.busy       = busy;
  assign bus.done       = done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      sel        <= '0;
      result     <= '0;
      sample_vld <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sample_vld <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= SETTLE;
            sel    <= '0;
            cnt    <= DW_M1;
            result <= '0;
            busy   <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) state <= CAPTURE;
          else             cnt   <= cnt - 8'd1;
        end
        CAPTURE: begin
          result[sel] <= bus.mux_y;
          sample_vld  <= 1'b1;
          if (sel == LAST) begin
            state <= DONE;
            sel   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= SETTLE;
            sel   <= sel + 1'b1;
            cnt   <= DW_M1;
          end
        end
        DONE: begin
`ifdef MUX_SCAN_CONT_EN
          // restart keeps old result bits until recaptured
          if (bus.start) begin
            state <= SETTLE;
            cnt   <= DW_M1;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer (4ch/dwell 3 and 2ch/dwell 1).
module tb_mux_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mux_scan_if #(.CHANNELS(4)) b0 ();
  mux_scan_if #(.CHANNELS(2)) b1 ();

  mux_scan_sequencer #(.CHANNELS(4), .DWELL(3)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  mux_scan_sequencer #(.CHANNELS(2), .DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  logic [3:0] d0;
  logic [1:0] d1;
  logic       gl;
  assign b0.mux_y = gl | d0[b0.sel];
  assign b1.mux_y = d1[b1.sel];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input int s, input bit v,
                      input bit b, input bit d, input logic [3:0] r);
    chk({tag, ".sel"}, 32'(b0.sel), 32'(s));
    chk({tag, ".vld"}, 32'(b0.sample_vld), 32'(v));
    chk({tag, ".busy"}, 32'(b0.busy), 32'(b));
    chk({tag, ".done"}, 32'(b0.done), 32'(d));
    chk({tag, ".res"}, 32'(b0.result), 32'(r));
  endtask

  // One full 4-channel scan from IDLE; t counts edges after acceptance.
  task automatic scan0(input string tag, input bit poke, input bit glt);
    logic [3:0] er;
    bit         p;
    er = 4'b0;
    b0.start = 1'b1;
    for (int t = 0; t <= 17; t++) begin
      cyc();
      for (int c = 0; c < 4; c++)
        if (t == 4 * (c + 1)) er[c] = d0[c];
      chk0($sformatf("%s.t%0d", tag, t), t < 16 ? t / 4 : 0,
           t >= 4 && t % 4 == 0 && t <= 16, t < 16, t == 16, er);
      p = poke && (t == 4 || t == 9 || t == 15);
`ifndef MUX_SCAN_CONT_EN
      p = p || (poke && t == 16);
`endif
      b0.start = p;
      gl = glt && t >= 4 && t <= 6;
    end
    b0.start = 1'b0;
    gl = 1'b0;
    cyc();
    chk({tag, ".idle_busy"}, 32'(b0.busy), 32'd0);
    chk({tag, ".idle_done"}, 32'(b0.done), 32'd0);
  endtask

  initial begin
    logic [1:0] e1;
    logic [3:0] er;
    int r;
    b0.start = 1'b0;
    b1.start = 1'b0;
    d0 = 4'b0;
    d1 = 2'b0;
    gl = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    chk0("reset", 0, 0, 0, 0, 4'b0);
    chk("reset.b1res", 32'(b1.result), 32'd0);
    cyc();
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    chk0("post_reset", 0, 0, 0, 0, 4'b0);

    d0 = 4'b1010;
    scan0("scan1010", 1'b0, 1'b0);

    d0 = 4'b0011;
    scan0("poke0011", 1'b1, 1'b0);

    d0 = 4'b0101;
    scan0("glitch0101", 1'b0, 1'b1);

    d1 = 2'b10;
    e1 = 2'b00;
    b1.start = 1'b1;
    for (int t = 0; t <= 5; t++) begin
      cyc();
      b1.start = 1'b0;
      for (int c = 0; c < 2; c++)
        if (t == 2 * (c + 1)) e1[c] = d1[c];
      chk($sformatf("c2.t%0d.sel", t), 32'(b1.sel), 32'(t < 4 ? t / 2 : 0));
      chk($sformatf("c2.t%0d.vld", t), 32'(b1.sample_vld),
          32'(t == 2 || t == 4));
      chk($sformatf("c2.t%0d.busy", t), 32'(b1.busy), 32'(t < 4));
      chk($sformatf("c2.t%0d.done", t), 32'(b1.done), 32'(t == 4));
      chk($sformatf("c2.t%0d.res", t), 32'(b1.result), 32'(e1));
    end

    // abort mid-scan after edge k+6
    d0 = 4'b1111;
    b0.start = 1'b1;
    for (int t = 0; t <= 6; t++) begin
      cyc();
      b0.start = 1'b0;
    end
    chk("abort.pre_busy", 32'(b0.busy), 32'd1);
    chk("abort.pre_res", 32'(b0.result), 32'd1);
    rst_n = 1'b0;
    #1;
    chk0("abort", 0, 0, 0, 0, 4'b0);
    #2 rst_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      cyc();
      chk($sformatf("abort.t%0d.done", t), 32'(b0.done), 32'd0);
      chk($sformatf("abort.t%0d.busy", t), 32'(b0.busy), 32'd0);
    end

    d0 = 4'b1001;
    scan0("after_abort", 1'b0, 1'b0);

`ifdef MUX_SCAN_CONT_EN
    // start held: restart from DONE at t=17, dropped during scan two
    d0 = 4'b1010;
    er = 4'b0;
    b0.start = 1'b1;
    for (int t = 0; t <= 35; t++) begin
      cyc();
      r = t < 17 ? t : t - 17;
      for (int c = 0; c < 4; c++)
        if (r == 4 * (c + 1)) er[c] = d0[c];
      chk0($sformatf("cont.t%0d", t), r < 16 ? r / 4 : 0,
           r >= 4 && r % 4 == 0 && r <= 16, r < 16, r == 16, er);
      if (t == 21) d0 = 4'b0110;
      if (t == 22) b0.start = 1'b0;
    end
    chk("cont.final_res", 32'(b0.result), 32'h6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
